// File: rtl/sram_burst_pkg.sv
// Shared types and elaboration helpers for the SRAM burst controller.
package sram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int beats_of(input int data_w, input int dq_w);
    return data_w / dq_w;
  endfunction

  // Counters still need one bit when they only ever hold zero.
  function automatic int cnt_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Nested wait/beat counter pair; the wait counter wraps once per beat and
// the beat counter wraps after the final beat of a burst.
module sram_beat_timer
  import sram_burst_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int BEATS       = 2,
  localparam int WW         = cnt_width(WAIT_CYCLES),
  localparam int BW         = cnt_width(BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [WW-1:0] w,
  output logic [BW-1:0] b,
  output logic          last_cycle,
  output logic          last_beat
);

  assign last_cycle = (w == WW'(WAIT_CYCLES - 1));
  assign last_beat  = (b == BW'(BEATS - 1));

  // Counters sit at zero whenever no access is running so the next burst starts clean.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      w <= '0;
      b <= '0;
    end else if (last_cycle) begin
      w <= '0;
      b <= last_beat ? '0 : b + 1'b1;
    end else begin
      w <= w + 1'b1;
    end
  end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Splits one pipeline load/store into half-word beats on an asynchronous SRAM,
// stalling the MEM stage through a combinational ready.
module sram_burst_ctrl
  import sram_burst_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_DQ_W   = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N
);

  localparam int BEATS   = beats_of(DATA_W, SRAM_DQ_W);
  localparam int BYTE_SH = clog2(DATA_W / 8);
  localparam int WW      = cnt_width(WAIT_CYCLES);
  localparam int BW      = cnt_width(BEATS);

  state_t                 state, next_state;
  logic                   start;
  logic                   run;
  logic                   is_write;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [SRAM_ADDR_W-1:0] base_q;
  logic [SRAM_ADDR_W-1:0] start_addr;
  logic [31:0]            word_idx;
  logic [WW-1:0]          w;
  logic [BW-1:0]          b;
  logic                   last_cycle;
  logic                   last_beat;
  logic                   dq_oe;
  logic [SRAM_DQ_W-1:0]   dq_out;

  // Addresses below the base simply wrap inside the SRAM address space.
  assign word_idx   = (addr - 32'(BASE_ADDR)) >> BYTE_SH;
  assign start_addr = SRAM_ADDR_W'(word_idx * 32'(BEATS));

  sram_beat_timer #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .BEATS      (BEATS)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .w         (w),
    .b         (b),
    .last_cycle(last_cycle),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      is_write <= 1'b0;
      wdata_q  <= '0;
      base_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        is_write <= wr_en;
        wdata_q  <= wdata;
        base_q   <= start_addr;
      end
      if (run && !is_write && last_cycle) begin
        for (int i = 0; i < BEATS; i++) begin
          if (b == BW'(i)) rdata_q[i*SRAM_DQ_W +: SRAM_DQ_W] <= SRAM_DQ;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        ready = ~(rd_en | wr_en);
        if (rd_en | wr_en) begin
          start      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (last_cycle && last_beat) next_state = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    dq_out = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (b == BW'(i)) dq_out = wdata_q[i*SRAM_DQ_W +: SRAM_DQ_W];
    end
  end

  assign run   = (state == ACCESS);
  assign dq_oe = is_write && run;

  // WE_N rises on the last cycle of every beat so address and data are held across it.
  assign SRAM_WE_N = ~(dq_oe && !last_cycle);
  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign SRAM_ADDR = base_q + SRAM_ADDR_W'(b);
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign rdata     = rdata_q;

  assert property (@(posedge clk) disable iff (rst) (start && wr_en) |-> (WAIT_CYCLES >= 2))
    else $error("sram_burst_ctrl: writes need WAIT_CYCLES >= 2");

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl: a default 32-bit instance and a 64-bit,
// two-wait-state instance, each with a small behavioural SRAM.
module tb_sram_burst_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        rd_a, wr_a, ready_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  wire  [15:0] dq_a;
  logic [17:0] sa_a;
  logic        we_a, ub_a, lb_a, ce_a, oe_a;

  logic        rd_b, wr_b, ready_b;
  logic [31:0] addr_b;
  logic [63:0] wdata_b, rdata_b;
  wire  [15:0] dq_b;
  logic [17:0] sa_b;
  logic        we_b, ub_b, lb_b, ce_b, oe_b;

  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:1023];
  bit          drv_a, drv_b;

  int checks;
  int failures;

  sram_burst_ctrl u_dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_a), .wr_en(wr_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .SRAM_DQ(dq_a),
    .SRAM_ADDR(sa_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a), .SRAM_CE_N(ce_a),
    .SRAM_OE_N(oe_a), .SRAM_WE_N(we_a)
  );

  sram_burst_ctrl #(.DATA_W(64), .WAIT_CYCLES(2)) u_dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_b), .wr_en(wr_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .SRAM_DQ(dq_b),
    .SRAM_ADDR(sa_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b), .SRAM_CE_N(ce_b),
    .SRAM_OE_N(oe_b), .SRAM_WE_N(we_b)
  );

  // Behavioural SRAMs: output enabled only while the bench expects a read.
  assign dq_a = (drv_a && we_a) ? mem_a[sa_a[9:0]] : 'z;
  assign dq_b = (drv_b && we_b) ? mem_b[sa_b[9:0]] : 'z;

  always @(negedge clk) begin
    if (!we_a) mem_a[sa_a[9:0]] = dq_a;
    if (!we_b) mem_b[sa_b[9:0]] = dq_b;
  end

  task automatic run_a(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       output int stall, output int we_low, output logic [17:0] first_addr);
    @(negedge clk);
    drv_a = r && !w; rd_a = r; wr_a = w; addr_a = a; wdata_a = d;
    stall = 0; we_low = 0;
    @(negedge clk);
    first_addr = sa_a;
    while (!ready_a && stall < 200) begin
      stall++;
      if (!we_a) we_low++;
      @(negedge clk);
    end
    rd_a = 1'b0; wr_a = 1'b0; drv_a = 1'b0;
    checks++;
    if (stall >= 200) begin failures++; $display("[TB] FAIL timeout_a: ready never rose for addr %0d", a); end
  endtask

  task automatic run_b(input bit w, input bit r, input logic [31:0] a, input logic [63:0] d,
                       output int stall, output int we_low, output logic [17:0] first_addr);
    @(negedge clk);
    drv_b = r && !w; rd_b = r; wr_b = w; addr_b = a; wdata_b = d;
    stall = 0; we_low = 0;
    @(negedge clk);
    first_addr = sa_b;
    while (!ready_b && stall < 200) begin
      stall++;
      if (!we_b) we_low++;
      @(negedge clk);
    end
    rd_b = 1'b0; wr_b = 1'b0; drv_b = 1'b0;
    checks++;
    if (stall >= 200) begin failures++; $display("[TB] FAIL timeout_b: ready never rose for addr %0d", a); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ready_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_a); end
    checks++; if (rdata_a !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata_a: got %h expected 0", rdata_a); end
    checks++; if (rdata_b !== 64'h0) begin failures++; $display("[TB] FAIL reset_rdata_b: got %h expected 0", rdata_b); end
    checks++; if (we_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_we_n: got %b expected 1", we_a); end
    checks++; if (sa_a !== 18'h0) begin failures++; $display("[TB] FAIL reset_sram_addr: got %h expected 0", sa_a); end
    checks++; if ({ub_a, lb_a, ce_a, oe_a} !== 4'b0000) begin failures++; $display("[TB] FAIL tied_strobes: got %b expected 0000", {ub_a, lb_a, ce_a, oe_a}); end
    rst = 1'b0;
    rd_a = 1'b1;
    #1;
    checks++; if (ready_a !== 1'b0) begin failures++; $display("[TB] FAIL idle_ready_req: got %b expected 0", ready_a); end
    rd_a = 1'b0;
  endtask

  task automatic test_write();
    int stall, we_low; logic [17:0] fa;
    run_a(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, stall, we_low, fa);
    checks++; if (stall !== 10) begin failures++; $display("[TB] FAIL write_stall: got %0d expected 10", stall); end
    checks++; if (we_low !== 8) begin failures++; $display("[TB] FAIL write_we_cycles: got %0d expected 8", we_low); end
    checks++; if (fa !== 18'd2) begin failures++; $display("[TB] FAIL write_first_addr: got %0d expected 2", fa); end
    checks++; if (mem_a[2] !== 16'hBEEF) begin failures++; $display("[TB] FAIL write_lo: got %h expected beef", mem_a[2]); end
    checks++; if (mem_a[3] !== 16'hDEAD) begin failures++; $display("[TB] FAIL write_hi: got %h expected dead", mem_a[3]); end
    checks++; if (rdata_a !== 32'h0) begin failures++; $display("[TB] FAIL write_keeps_rdata: got %h expected 0", rdata_a); end
  endtask

  task automatic test_read();
    int stall, we_low; logic [17:0] fa;
    run_a(1'b0, 1'b1, 32'd1028, 32'h0, stall, we_low, fa);
    checks++; if (rdata_a !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL read_data: got %h expected deadbeef", rdata_a); end
    checks++; if (we_low !== 0) begin failures++; $display("[TB] FAIL read_we_cycles: got %0d expected 0", we_low); end
    checks++; if (stall !== 10) begin failures++; $display("[TB] FAIL read_stall: got %0d expected 10", stall); end
  endtask

  task automatic test_write_priority();
    int stall, we_low; logic [17:0] fa;
    run_a(1'b1, 1'b1, 32'd1024, 32'h12345678, stall, we_low, fa);
    checks++; if (mem_a[0] !== 16'h5678) begin failures++; $display("[TB] FAIL prio_lo: got %h expected 5678", mem_a[0]); end
    checks++; if (mem_a[1] !== 16'h1234) begin failures++; $display("[TB] FAIL prio_hi: got %h expected 1234", mem_a[1]); end
    checks++; if (rdata_a !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL prio_rdata: got %h expected deadbeef", rdata_a); end
    checks++; if (we_low !== 8) begin failures++; $display("[TB] FAIL prio_we_cycles: got %0d expected 8", we_low); end
  endtask

  task automatic test_addr_wrap();
    int stall, we_low; logic [17:0] fa;
    mem_a[1022] = 16'hC0DE;
    mem_a[1023] = 16'hF00D;
    run_a(1'b0, 1'b1, 32'd1020, 32'h0, stall, we_low, fa);
    checks++; if (fa !== 18'h3FFFE) begin failures++; $display("[TB] FAIL wrap_addr: got %h expected 3fffe", fa); end
    checks++; if (rdata_a !== 32'hF00DC0DE) begin failures++; $display("[TB] FAIL wrap_data: got %h expected f00dc0de", rdata_a); end
  endtask

  task automatic test_wide_config();
    int stall, we_low; logic [17:0] fa;
    run_b(1'b1, 1'b0, 32'd1032, 64'h0123456789ABCDEF, stall, we_low, fa);
    checks++; if (stall !== 8) begin failures++; $display("[TB] FAIL wide_write_stall: got %0d expected 8", stall); end
    checks++; if (we_low !== 4) begin failures++; $display("[TB] FAIL wide_we_cycles: got %0d expected 4", we_low); end
    checks++; if (fa !== 18'd4) begin failures++; $display("[TB] FAIL wide_first_addr: got %0d expected 4", fa); end
    checks++;
    if ({mem_b[7], mem_b[6], mem_b[5], mem_b[4]} !== 64'h0123456789ABCDEF) begin
      failures++;
      $display("[TB] FAIL wide_mem: got %h%h%h%h expected 0123456789abcdef", mem_b[7], mem_b[6], mem_b[5], mem_b[4]);
    end
    run_b(1'b0, 1'b1, 32'd1032, 64'h0, stall, we_low, fa);
    checks++; if (rdata_b !== 64'h0123456789ABCDEF) begin failures++; $display("[TB] FAIL wide_read: got %h expected 0123456789abcdef", rdata_b); end
    checks++; if (stall !== 8) begin failures++; $display("[TB] FAIL wide_read_stall: got %0d expected 8", stall); end
  endtask

  task automatic test_reset_mid_write();
    int stall, we_low; logic [17:0] fa;
    @(negedge clk);
    drv_a = 1'b0; wr_a = 1'b1; addr_a = 32'd1036; wdata_a = 32'h13579BDF;
    // Eighth ACCESS cycle is beat 1, wait count 2.
    repeat (8) @(negedge clk);
    checks++; if (we_a !== 1'b0) begin failures++; $display("[TB] FAIL midwrite_we_active: got %b expected 0", we_a); end
    rst = 1'b1;
    wr_a = 1'b0;
    @(negedge clk);
    checks++; if (ready_a !== 1'b1) begin failures++; $display("[TB] FAIL midreset_idle: got ready %b expected 1", ready_a); end
    checks++; if (we_a !== 1'b1) begin failures++; $display("[TB] FAIL midreset_we_n: got %b expected 1", we_a); end
    rst = 1'b0;
    checks++; if (mem_a[6] !== 16'h9BDF) begin failures++; $display("[TB] FAIL midreset_beat0: got %h expected 9bdf", mem_a[6]); end
    run_a(1'b0, 1'b1, 32'd1036, 32'h0, stall, we_low, fa);
    checks++; if (stall !== 10) begin failures++; $display("[TB] FAIL midreset_read_stall: got %0d expected 10", stall); end
    checks++; if (rdata_a !== 32'h13579BDF) begin failures++; $display("[TB] FAIL midreset_read_data: got %h expected 13579bdf", rdata_a); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_words [4];
    int cnt;
    exp_words[0] = 32'h1111AAAA;
    exp_words[1] = 32'h2222BBBB;
    exp_words[2] = 32'h3333CCCC;
    exp_words[3] = 32'h4444DDDD;
    for (int k = 0; k < 4; k++) begin
      mem_a[10 + 2*k] = exp_words[k][15:0];
      mem_a[11 + 2*k] = exp_words[k][31:16];
    end
    @(negedge clk);
    drv_a = 1'b1; rd_a = 1'b1; addr_a = 32'd1044;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      @(negedge clk);
      while (!ready_a && cnt < 200) begin
        cnt++;
        @(negedge clk);
      end
      // After the first load, one IDLE cycle precedes each ACCESS phase.
      checks++;
      if (cnt !== ((k == 0) ? 10 : 11)) begin
        failures++;
        $display("[TB] FAIL b2b_gap_%0d: got %0d expected %0d", k, cnt, (k == 0) ? 10 : 11);
      end
      checks++;
      if (rdata_a !== exp_words[k]) begin
        failures++;
        $display("[TB] FAIL b2b_data_%0d: got %h expected %h", k, rdata_a, exp_words[k]);
      end
      if (k < 3) addr_a = 32'd1044 + 32'(4 * (k + 1));
      else rd_a = 1'b0;
    end
    drv_a = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 16'h0;
      mem_b[i] = 16'h0;
    end
    rst = 1'b1;
    rd_a = 1'b0; wr_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0; drv_a = 1'b0;
    rd_b = 1'b0; wr_b = 1'b0; addr_b = 32'h0; wdata_b = 64'h0; drv_b = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_write_priority();
    test_addr_wrap();
    test_wide_config();
    test_reset_mid_write();
    test_back_to_back();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
